// File: rtl/key_input_port_pkg.sv
// Shared definitions for the key input port: register offsets, event and
// status bit positions, the pending-event payload type and the event packer.
package key_input_port_pkg;

  localparam int REG_STATE  = 0;
  localparam int REG_STATUS = 1;
  localparam int REG_EVENT  = 2;

  localparam int EV_VALID  = 15;
  localparam int EV_REPEAT = 9;
  localparam int EV_PRESS  = 8;

  localparam int ST_NONEMPTY  = 0;
  localparam int ST_COUNT_LSB = 1;
  localparam int ST_OVERFLOW  = 5;

  typedef struct packed {
    logic rpt;
    logic press;
  } key_ev_t;

  function automatic logic [15:0] make_event(input key_ev_t ev, input logic [3:0] idx);
    logic [15:0] w;
    w            = '0;
    w[EV_VALID]  = 1'b1;
    w[EV_REPEAT] = ev.rpt;
    w[EV_PRESS]  = ev.press;
    w[3:0]       = idx;
    return w;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-FF synchroniser, mismatch-run debouncer and pending-event flag.
// Optional auto-repeat timer is built only when KEY_REPEAT_EN is defined.
module key_debounce
  import key_input_port_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 120000
`ifdef KEY_REPEAT_EN
  , parameter int REPEAT_DELAY  = 6000000
  , parameter int REPEAT_PERIOD = 1200000
`endif
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    key,
  input  logic    ack,
  output logic    state,
  output logic    pending,
  output key_ev_t ev
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rcnt;
  logic          rfirst;
  logic [RW-1:0] rlimit;

  // First repeat waits the long delay, later ones the short period.
  assign rlimit = rfirst ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= '0;
      state   <= 1'b0;
      pending <= 1'b0;
      ev      <= '0;
`ifdef KEY_REPEAT_EN
      rcnt    <= '0;
      rfirst  <= 1'b1;
`endif
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      if (ack) pending <= 1'b0;
`ifdef KEY_REPEAT_EN
      if (!state) begin
        rcnt   <= '0;
        rfirst <= 1'b1;
      end else if (rcnt == rlimit) begin
        rcnt    <= '0;
        rfirst  <= 1'b0;
        pending <= 1'b1;
        ev      <= '{rpt: 1'b1, press: 1'b1};
      end else begin
        rcnt <= rcnt + RW'(1);
      end
`endif
      // A state flip is written last so a release beats a same-cycle repeat.
      if (sync2 == state) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt     <= '0;
        state   <= sync2;
        pending <= 1'b1;
        ev      <= '{rpt: 1'b0, press: sync2};
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/key_input_port.sv
// CPU-readable key input peripheral: per-key debouncers, event FIFO, push
// arbiter and I/O register decode. Optional auto-repeat: KEY_REPEAT_EN.
module key_input_port
  import key_input_port_pkg::*;
#(
  parameter int          NKEYS           = 4,
  parameter int          DEBOUNCE_CYCLES = 120000,
  parameter int          FIFO_DEPTH      = 8,
  parameter logic [15:0] BASE_ADDR       = 16'h0004
`ifdef KEY_REPEAT_EN
  , parameter int        REPEAT_DELAY    = 6000000
  , parameter int        REPEAT_PERIOD   = 1200000
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] key,
  input  logic [15:0]      addr,
  input  logic [15:0]      bus,
  input  logic             DI,
  input  logic             DO,
  output logic [15:0]      busin,
  output logic             irq
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] A_STATE  = BASE_ADDR + 16'(REG_STATE);
  localparam logic [15:0] A_STATUS = BASE_ADDR + 16'(REG_STATUS);
  localparam logic [15:0] A_EVENT  = BASE_ADDR + 16'(REG_EVENT);

  // Event handshake: a debouncer raises pending (valid) with its payload and
  // holds both until ack; ack is a one-cycle grant on the clk the arbiter
  // takes the event, whether it is pushed or dropped on a full FIFO.
  logic [NKEYS-1:0] state;
  logic [NKEYS-1:0] pending;
  logic [NKEYS-1:0] ack;
  key_ev_t          ev [NKEYS];

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEY_REPEAT_EN
      , .REPEAT_DELAY (REPEAT_DELAY)
      , .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .key    (key[i]),
      .ack    (ack[i]),
      .state  (state[i]),
      .pending(pending[i]),
      .ev     (ev[i])
    );
  end

  logic          grant_valid;
  logic [3:0]    grant_idx;
  key_ev_t       grant_ev;

  // Lowest pending index wins; isolating the lowest set bit gives the ack.
  always_comb begin
    grant_valid = |pending;
    grant_idx   = '0;
    grant_ev    = '0;
    ack         = pending & (~pending + NKEYS'(1));
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant_idx = 4'(i);
        grant_ev  = ev[i];
      end
    end
  end

  logic [15:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic [AW:0] count_next;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        drop;
  logic        sel_event;
  logic        sel_event_q;
  logic        di_q;
  logic        ov_clear;
  logic        overflow;

  assign sel_event  = DO && (addr == A_EVENT);
  assign count      = wr_ptr - rd_ptr;
  assign empty      = (count == '0);
  assign full       = (count == (AW + 1)'(FIFO_DEPTH));
  // Pop on the falling edge of the event-register access, so the head stays put while it is read.
  assign pop        = sel_event_q && !sel_event && !empty;
  assign push       = grant_valid && (!full || pop);
  assign drop       = grant_valid && full && !pop;
  assign ov_clear   = DI && !di_q && (addr == A_STATUS) && bus[ST_OVERFLOW];
  assign count_next = (wr_ptr + (AW + 1)'(push)) - (rd_ptr + (AW + 1)'(pop));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= make_event(grant_ev, grant_idx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      sel_event_q <= 1'b0;
      di_q        <= 1'b0;
      overflow    <= 1'b0;
      irq         <= 1'b0;
    end else begin
      sel_event_q <= sel_event;
      di_q        <= DI;
      if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
      if (ov_clear) overflow <= 1'b0;
      if (drop)     overflow <= 1'b1;
      irq <= (count_next != '0);
    end
  end

  logic [3:0]  count_sat;
  logic [15:0] status_word;
  logic [15:0] head_word;

  always_comb begin
    count_sat = (32'(count) > 15) ? 4'd15 : 4'(count);
    status_word                             = '0;
    status_word[ST_OVERFLOW]                = overflow;
    status_word[ST_COUNT_LSB +: 4]          = count_sat;
    status_word[ST_NONEMPTY]                = !empty;
    head_word = empty ? 16'h0000 : mem[rd_ptr[AW-1:0]];
    busin = 16'h0000;
    if (DO) begin
      if (addr == A_STATE)  busin = 16'(state);
      if (addr == A_STATUS) busin = status_word;
      if (addr == A_EVENT)  busin = head_word;
    end
  end

  logic unused_bus;
  assign unused_bus = ^{bus[15:6], bus[4:0]};

endmodule

// File: tb/tb_key_input_port.sv
// Directed bench for key_input_port: a queue-based event model checked every
// cycle, plus literal register reads. Define KEY_REPEAT_EN to add the repeat test.
module tb_key_input_port;

  localparam int          NK    = 4;
  localparam int          DB    = 4;
  localparam int          DEPTH = 4;
  localparam logic [15:0] BASE  = 16'h0004;
`ifdef KEY_REPEAT_EN
  localparam int          RD    = 10;
  localparam int          RP    = 5;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] key = '0;
  logic [15:0]   addr = '0;
  logic [15:0]   bus = '0;
  logic          DI = 1'b0;
  logic          DO = 1'b0;
  logic [15:0]   busin;
  logic          irq;

  int n_vec = 0;
  int n_mis = 0;

  key_input_port #(
    .NKEYS          (NK),
    .DEBOUNCE_CYCLES(DB),
    .FIFO_DEPTH     (DEPTH),
    .BASE_ADDR      (BASE)
`ifdef KEY_REPEAT_EN
    , .REPEAT_DELAY (RD)
    , .REPEAT_PERIOD(RP)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .key  (key),
    .addr (addr),
    .bus  (bus),
    .DI   (DI),
    .DO   (DO),
    .busin(busin),
    .irq  (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural model: keys seen two clocks late, accepted after DB
  // consecutive differing samples, events queued in exp_q
  logic [15:0]   exp_q[$];
  logic [NK-1:0] m_state = '0;
  logic [NK-1:0] kd1 = '0;
  logic [NK-1:0] kd2 = '0;
  int            m_run[NK];
  int            m_held[NK];
  bit            m_pend[NK];
  logic [15:0]   m_pev[NK];
  bit            m_ov = 0;
  bit            m_sel_prev = 0;
  bit            m_di_prev = 0;
  bit            m_armed = 0;

  always @(posedge clk) begin
    bit sel_now, do_pop, was_full, found, dropped, clear, prev;
    m_armed = 1;
    if (reset) begin
      exp_q.delete();
      m_state = '0; kd1 = '0; kd2 = '0;
      m_ov = 0; m_sel_prev = 0; m_di_prev = 0;
      for (int k = 0; k < NK; k++) begin
        m_run[k] = 0; m_held[k] = 0; m_pend[k] = 0; m_pev[k] = '0;
      end
    end else begin
      sel_now  = DO && (addr == BASE + 16'd2);
      was_full = (exp_q.size() == DEPTH);
      do_pop   = m_sel_prev && !sel_now && (exp_q.size() > 0);
      if (do_pop) void'(exp_q.pop_front());
      found = 0; dropped = 0;
      for (int k = 0; k < NK; k++) begin
        if (m_pend[k] && !found) begin
          found = 1;
          m_pend[k] = 0;
          if (was_full && !do_pop) dropped = 1;
          else exp_q.push_back(m_pev[k]);
        end
      end
      clear = DI && !m_di_prev && (addr == BASE + 16'd1) && bus[5];
      m_ov  = dropped ? 1'b1 : (clear ? 1'b0 : m_ov);
      for (int k = 0; k < NK; k++) begin
        prev = m_state[k];
`ifdef KEY_REPEAT_EN
        if (prev) begin
          m_held[k]++;
          if (m_held[k] == RD || (m_held[k] > RD && (m_held[k] - RD) % RP == 0)) begin
            m_pend[k] = 1;
            m_pev[k]  = 16'h8300 | 16'(k);
          end
        end else begin
          m_held[k] = 0;
        end
`endif
        if (kd2[k] != prev) m_run[k]++;
        else m_run[k] = 0;
        if (m_run[k] == DB) begin
          m_run[k]   = 0;
          m_state[k] = kd2[k];
          m_pend[k]  = 1;
          m_pev[k]   = (kd2[k] ? 16'h8100 : 16'h8000) | 16'(k);
        end
      end
      kd2 = kd1;
      kd1 = key;
      m_sel_prev = sel_now;
      m_di_prev  = DI;
    end
  end

  function automatic logic [15:0] model_busin();
    int c;
    c = exp_q.size();
    if (!DO) return 16'h0000;
    if (addr == BASE) return 16'(m_state);
    if (addr == BASE + 16'd1) return {10'b0, m_ov, 4'((c > 15) ? 15 : c), c != 0};
    if (addr == BASE + 16'd2) return (c != 0) ? exp_q[0] : 16'h0000;
    return 16'h0000;
  endfunction

  // scoreboard: compare every cycle on the falling edge
  always @(negedge clk) begin
    logic [15:0] eb;
    logic        ei;
    if (m_armed) begin
      eb = model_busin();
      ei = (exp_q.size() != 0);
      n_vec++;
      if (busin !== eb) begin
        n_mis++;
        $display("FAIL busin_model t=%0t got=%h want=%h", $time, busin, eb);
      end
      n_vec++;
      if (irq !== ei) begin
        n_mis++;
        $display("FAIL irq_model t=%0t got=%b want=%b", $time, irq, ei);
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string name);
    addr = a;
    DO   = 1'b1;
    #2;
    chk(name, busin, exp);
    step(3);
    DO   = 1'b0;
    addr = '0;
    step(1);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr = a;
    bus  = d;
    DI   = 1'b1;
    step(3);
    DI   = 1'b0;
    addr = '0;
    bus  = '0;
    step(1);
  endtask

  initial begin
    int w;
    step(3);
    chk("reset_irq", 16'(irq), 16'h0000);
    rd(BASE + 16'd1, 16'h0000, "reset_status");
    reset = 1'b0;
    step(2);

    // glitch shorter than the debounce window
    key[2] = 1'b1; step(2); key[2] = 1'b0; step(10);
    rd(BASE, 16'h0000, "glitch_state");
    chk("glitch_irq", 16'(irq), 16'h0000);

    // single press, bounded wait for the event
    key[2] = 1'b1;
    w = 0;
    while (!irq && w < 30) begin step(1); w++; end
    chk("press_irq_within_budget", 16'(irq), 16'h0001);
    rd(BASE + 16'd2, 16'h8102, "press_event");
    rd(BASE + 16'd1, 16'h0000, "status_after_pop");
    key[2] = 1'b0; step(10);
    rd(BASE + 16'd2, 16'h8002, "release_event");

    // simultaneous presses: lowest index first
    key[0] = 1'b1; key[3] = 1'b1; step(12);
    rd(BASE + 16'd1, 16'h0005, "two_events_status");
    chk("two_events_irq", 16'(irq), 16'h0001);
    rd(BASE + 16'd2, 16'h8100, "order_first");
    rd(BASE + 16'd2, 16'h8103, "order_second");
    key = '0; step(12);
    rd(BASE + 16'd2, 16'h8000, "rel_first");
    rd(BASE + 16'd2, 16'h8003, "rel_second");

    // five events into four slots
    key = 4'b0011; step(12);
    key = 4'b1111; step(12);
    key = 4'b1110; step(12);
    rd(BASE + 16'd1, 16'h0029, "overflow_status");
    wr(BASE + 16'd1, 16'h0020);
    rd(BASE + 16'd1, 16'h0009, "overflow_cleared");

    // long access: head stable, one pop
    addr = BASE + 16'd2; DO = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk("hold_stable", busin, 16'h8100);
    end
    DO = 1'b0; addr = '0; step(1);
    rd(BASE + 16'd1, 16'h0007, "one_pop_status");
    rd(BASE + 16'd2, 16'h8101, "drain_1");
    rd(BASE + 16'd2, 16'h8102, "drain_2");
    rd(BASE + 16'd2, 16'h8103, "drain_3");
    rd(BASE + 16'd2, 16'h0000, "empty_read");
    rd(BASE + 16'd1, 16'h0000, "empty_status");
    rd(BASE, 16'h000E, "state_1110");

    // reset in the middle of an event access
    key = '0; step(12);
    rd(BASE + 16'd1, 16'h0007, "three_releases");
    addr = BASE + 16'd2; DO = 1'b1; step(2);
    reset = 1'b1; step(1);
    DO = 1'b0; addr = '0; step(2);
    reset = 1'b0; step(1);
    rd(BASE + 16'd1, 16'h0000, "reset_mid_access");
    chk("reset_mid_irq", 16'(irq), 16'h0000);

`ifdef KEY_REPEAT_EN
    key[1] = 1'b1; step(28);
    key[1] = 1'b0; step(12);
    rd(BASE + 16'd2, 16'h8101, "repeat_press");
    rd(BASE + 16'd2, 16'h8301, "repeat_first");
    w = 0;
    while (irq && w < 10) begin
      addr = BASE + 16'd2; DO = 1'b1; step(3);
      DO = 1'b0; addr = '0; step(1);
      w++;
    end
    chk("repeat_drained", 16'(irq), 16'h0000);
`endif

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
